// File: rtl/grf_wb_if.sv
// grf_wb_if -- register-file writeback bus between two requesters and the
// GRF write-port arbiter.
//   Requester 0 (pipeline writeback) : Req0, Addr0, Data0, PC0 -> Gnt0
//   Requester 1 (mult/div result)    : Req1, Addr1, Data1, PC1 -> Gnt1
//   GRF write port (registered)      : WriteEn, WriteAddress, WriteData, PC, Busy
// Modports:
//   master : requester/consumer side (drives requests, sees grants and writes)
//   slave  : arbiter side
interface grf_wb_if;
  logic        Req0;
  logic [4:0]  Addr0;
  logic [31:0] Data0;
  logic [31:0] PC0;
  logic        Req1;
  logic [4:0]  Addr1;
  logic [31:0] Data1;
  logic [31:0] PC1;
  logic        Gnt0;
  logic        Gnt1;
  logic        WriteEn;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;
  logic [31:0] PC;
  logic        Busy;

  modport master (
    output Req0, Addr0, Data0, PC0,
    output Req1, Addr1, Data1, PC1,
    input  Gnt0, Gnt1,
    input  WriteEn, WriteAddress, WriteData, PC, Busy
  );

  modport slave (
    input  Req0, Addr0, Data0, PC0,
    input  Req1, Addr1, Data1, PC1,
    output Gnt0, Gnt1,
    output WriteEn, WriteAddress, WriteData, PC, Busy
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter -- two-requester round-robin arbiter feeding the GRF write
// port through one register stage.
//   Clk   : clock, all state on posedge
//   Reset : synchronous, active-high
//   bus   : grf_wb_if.slave
//     Req/Addr/Data/PC 0,1 in : held stable by each requester until granted
//     Gnt0/Gnt1 out (comb)    : payload accepted at the coming posedge
//     WriteEn/WriteAddress/WriteData/PC/Busy out (registered) : the granted
//       write, one cycle after its grant
// A grant goes straight to a lone requester; when both request, the one that
// was not granted most recently wins, so held requests strictly alternate.
module grf_wb_arbiter (
  input  logic     Clk,
  input  logic     Reset,
  grf_wb_if.slave  bus
);
  localparam int NUM_REQ = 2;

  // Requester views gathered into packed arrays so the payload mux is an index.
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0][4:0]  addr;
  logic [NUM_REQ-1:0][31:0] data;
  logic [NUM_REQ-1:0][31:0] pc;

  assign req  = {bus.Req1,  bus.Req0};
  assign addr = {bus.Addr1, bus.Addr0};
  assign data = {bus.Data1, bus.Data0};
  assign pc   = {bus.PC1,   bus.PC0};

  // ---------------------------------------------------------------------------
  // Priority pointer: last_q holds the most recent grantee.
  // ---------------------------------------------------------------------------
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] gnt;
  logic               sel;
  logic               any_gnt;

  always_ff @(posedge Clk) begin
    if (Reset) last_q <= 1'b1;  // requester 0 goes first after reset
    else       last_q <= last_d;
  end

  // Pointer moves only on a grant; idle cycles keep the current priority.
  always_comb begin
    last_d = last_q;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;
  end

  // Requester 0 wins if alone or if requester 1 was served last.
  always_comb begin
    gnt = '0;
    if (!Reset) begin
      if (req[0] && (!req[1] || last_q)) gnt[0] = 1'b1;
      else if (req[1])                   gnt[1] = 1'b1;
    end
  end

  assign sel      = gnt[1];
  assign any_gnt  = |gnt;
  assign bus.Gnt0 = gnt[0];
  assign bus.Gnt1 = gnt[1];

  // ---------------------------------------------------------------------------
  // Write stage: registers the granted payload for one cycle.
  // ---------------------------------------------------------------------------
  logic        we_q,    we_d;
  logic        busy_q,  busy_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q,    pc_d;

  always_comb begin
    we_d    = 1'b0;
    busy_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    if (any_gnt) begin
      busy_d  = 1'b1;
      // $0 is hardwired: consume the write but keep the strobe low.
      we_d    = (addr[sel] != 5'd0);
      waddr_d = addr[sel];
      wdata_d = data[sel];
      pc_d    = pc[sel];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
    end else begin
      we_q    <= we_d;
      busy_q  <= busy_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.WriteEn      = we_q;
  assign bus.Busy         = busy_q;
  assign bus.WriteAddress = waddr_q;
  assign bus.WriteData    = wdata_q;
  assign bus.PC           = pc_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios with literal expectations,
// then randomized requesters, all continuously compared against a
// behavioural model of the arbitration and writeback rules.
module tb_grf_wb_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  grf_wb_if bus();

  grf_wb_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: who was served last, plus the write expected on the port.
  int          m_last = 1;
  bit          m_we = 1'b0, m_busy = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0, m_pc = '0;
  logic [31:0] m_grf [32];
  logic [31:0] d_grf [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // -1: nobody granted; else index of the requester that must be granted.
  function automatic int exp_grant();
    if (Reset) return -1;
    if (bus.Req0 && bus.Req1) return (m_last == 0) ? 1 : 0;
    if (bus.Req0) return 0;
    if (bus.Req1) return 1;
    return -1;
  endfunction

  // Compare every cycle, then advance the model across the coming posedge.
  always @(negedge Clk) begin
    int g;
    g = exp_grant();
    if (cmp_en) begin
      chk("gnt0",  32'(bus.Gnt0), 32'(g == 0));
      chk("gnt1",  32'(bus.Gnt1), 32'(g == 1));
      chk("we",    32'(bus.WriteEn), 32'(m_we));
      chk("busy",  32'(bus.Busy), 32'(m_busy));
      chk("waddr", 32'(bus.WriteAddress), 32'(m_addr));
      chk("wdata", bus.WriteData, m_data);
      chk("pc",    bus.PC, m_pc);
      if (bus.WriteEn === 1'b1) d_grf[bus.WriteAddress] = bus.WriteData;
    end
    if (Reset) begin
      m_we = 0; m_busy = 0; m_addr = '0; m_data = '0; m_pc = '0; m_last = 1;
    end else if (g >= 0) begin
      m_addr = (g == 0) ? bus.Addr0 : bus.Addr1;
      m_data = (g == 0) ? bus.Data0 : bus.Data1;
      m_pc   = (g == 0) ? bus.PC0   : bus.PC1;
      m_busy = 1;
      m_we   = (m_addr != 0);
      m_last = g;
      if (m_we) m_grf[m_addr] = m_data;
    end else begin
      m_we = 0; m_busy = 0;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    bus.Req0 = r; bus.Addr0 = a; bus.Data0 = d; bus.PC0 = p;
  endtask

  task automatic set1(input logic r, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    bus.Req1 = r; bus.Addr1 = a; bus.Data1 = d; bus.PC1 = p;
  endtask

  task automatic rnd_payload(input int r);
    logic [4:0]  a;
    logic [31:0] d, p;
    a = 5'($urandom_range(0, 7));  // narrow range: frequent collisions and $0
    d = $urandom;
    p = {$urandom_range(0, 65535), 2'b00} & 32'h000F_FFFC;
    if (r == 0) set0(1'b1, a, d, p);
    else        set1(1'b1, a, d, p);
  endtask

  initial begin
    logic g0, g1;
    for (int i = 0; i < 32; i++) begin m_grf[i] = '0; d_grf[i] = '0; end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);

    // Reset state; requests during reset get no grant.
    tick();
    cmp_en = 1'b1;
    set0(1, 5'd4, 32'h1, 32'h10);
    set1(1, 5'd6, 32'h2, 32'h20);
    @(negedge Clk);
    chk("rst_gnt0", 32'(bus.Gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.Gnt1), 32'd0);
    chk("rst_we", 32'(bus.WriteEn), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_wd", bus.WriteData, 32'd0);
    chk("rst_pc", bus.PC, 32'd0);

    // Single write, zero-wait grant, one-cycle latency.
    tick();
    Reset = 0;
    set1(0, 0, 0, 0);
    set0(1, 5'd8, 32'h1234_5678, 32'h3000);
    @(negedge Clk);
    chk("single_gnt0", 32'(bus.Gnt0), 32'd1);
    tick();
    set0(0, 0, 0, 0);
    @(negedge Clk);
    chk("single_we", 32'(bus.WriteEn), 32'd1);
    chk("single_wa", 32'(bus.WriteAddress), 32'd8);
    chk("single_wd", bus.WriteData, 32'h1234_5678);
    chk("single_pc", bus.PC, 32'h3000);

    // Right after reset, both held: grants alternate 0,1,0,1.
    tick();
    Reset = 1;
    tick();
    Reset = 0;
    set0(1, 5'd1, 32'd100, 32'h100);
    set1(1, 5'd2, 32'd200, 32'h200);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("alt_gnt0", 32'(bus.Gnt0), 32'(k % 2 == 0));
      chk("alt_gnt1", 32'(bus.Gnt1), 32'(k % 2 == 1));
      if (k > 0) chk("alt_we", 32'(bus.WriteEn), 32'd1);
      tick();
      if (k % 2 == 0) set0(1, 5'd1, 32'(101 + k), 32'h104);
      else            set1(1, 5'd2, 32'(201 + k), 32'h204);
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    @(negedge Clk);
    chk("alt_we_last", 32'(bus.WriteEn), 32'd1);

    // Same destination from both: 0xA then 0xB, no merging.
    tick();
    set0(1, 5'd5, 32'hA, 32'h500);
    set1(1, 5'd5, 32'hB, 32'h504);
    @(negedge Clk);
    chk("same_gnt0", 32'(bus.Gnt0), 32'd1);
    tick();
    set0(0, 0, 0, 0);
    @(negedge Clk);
    chk("same_gnt1", 32'(bus.Gnt1), 32'd1);
    chk("same_wd0", bus.WriteData, 32'hA);
    tick();
    set1(0, 0, 0, 0);
    @(negedge Clk);
    chk("same_wd1", bus.WriteData, 32'hB);
    chk("same_we1", 32'(bus.WriteEn), 32'd1);

    // Write to $0: consumed, Busy but no strobe.
    tick();
    set1(1, 5'd0, 32'hFFFF_FFFF, 32'h600);
    @(negedge Clk);
    chk("zero_gnt1", 32'(bus.Gnt1), 32'd1);
    tick();
    set1(0, 0, 0, 0);
    @(negedge Clk);
    chk("zero_busy", 32'(bus.Busy), 32'd1);
    chk("zero_we", 32'(bus.WriteEn), 32'd0);

    // Reset right after a grant discards the pending write.
    tick();
    set0(1, 5'd3, 32'h33, 32'h44);
    @(negedge Clk);
    chk("rip_gnt0", 32'(bus.Gnt0), 32'd1);
    tick();
    set0(0, 0, 0, 0);
    Reset = 1;
    set1(1, 5'd9, 32'h99, 32'h90);
    @(negedge Clk);
    chk("rip_nognt", 32'(bus.Gnt1), 32'd0);
    chk("rip_we_shown", 32'(bus.WriteEn), 32'd1);
    tick();
    Reset = 0;
    @(negedge Clk);
    chk("rip_we", 32'(bus.WriteEn), 32'd0);
    chk("rip_wa", 32'(bus.WriteAddress), 32'd0);
    chk("rip_wd", bus.WriteData, 32'd0);
    chk("rip_held_gnt1", 32'(bus.Gnt1), 32'd1);
    tick();
    set1(0, 0, 0, 0);

    // Req0 alone for 3 cycles, then Req1 joins and wins at once.
    for (int k = 0; k < 3; k++) begin
      set0(1, 5'(10 + k), 32'(k), 32'h700);
      @(negedge Clk);
      chk("solo_gnt0", 32'(bus.Gnt0), 32'd1);
      tick();
    end
    set0(1, 5'd13, 32'h13, 32'h70C);
    set1(1, 5'd14, 32'h14, 32'h710);
    @(negedge Clk);
    chk("join_gnt1", 32'(bus.Gnt1), 32'd1);
    chk("join_gnt0", 32'(bus.Gnt0), 32'd0);
    tick();
    set1(0, 0, 0, 0);
    @(negedge Clk);
    chk("join_gnt0_next", 32'(bus.Gnt0), 32'd1);
    tick();
    set0(0, 0, 0, 0);
    // Two idle cycles must not move priority: requester 1 still wins.
    tick();
    tick();
    set0(1, 5'd15, 32'h15, 32'h800);
    set1(1, 5'd16, 32'h16, 32'h804);
    @(negedge Clk);
    chk("idle_keep_gnt1", 32'(bus.Gnt1), 32'd1);
    tick();
    // Req0 abandons its pending request: no grant, no write.
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    @(negedge Clk);
    chk("drop_gnt0", 32'(bus.Gnt0), 32'd0);
    tick();
    @(negedge Clk);
    chk("drop_we", 32'(bus.WriteEn), 32'd0);
    chk("drop_busy", 32'(bus.Busy), 32'd0);

    // Randomized requesters obeying the hold-until-granted handshake,
    // with occasional abandonment and rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      g0 = bus.Gnt0;
      g1 = bus.Gnt1;
      @(posedge Clk);
      #1;
      Reset = ($urandom_range(0, 199) == 0);
      if (bus.Req0 && !g0) begin
        if ($urandom_range(0, 49) == 0) set0(0, 0, 0, 0);
      end else if ($urandom_range(0, 99) < 60) rnd_payload(0);
      else set0(0, 0, 0, 0);
      if (bus.Req1 && !g1) begin
        if ($urandom_range(0, 49) == 0) set1(0, 0, 0, 0);
      end else if ($urandom_range(0, 99) < 45) rnd_payload(1);
      else set1(0, 0, 0, 0);
    end
    tick();
    Reset = 0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    tick();
    tick();
    @(negedge Clk);

    // Final register contents seen on the write port versus the model.
    for (int i = 0; i < 32; i++) chk("grf_final", d_grf[i], m_grf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
